// File: rtl/lsu_bus.sv
// Load/store unit bridging the EX stage to a request/grant/response data bus.
// Builds byte enables and lane-replicated store data, then returns extended load data or an error code.
module lsu_bus #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [2:0]        req_size_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [4:0]        req_rd_addr_i,
  output logic              req_ready_o,
  output logic              stall_o,
  output logic              rsp_valid_o,
  output logic [4:0]        rsp_rd_addr_o,
  output logic [31:0]       rsp_rdata_o,
  output logic [1:0]        rsp_err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_err_i
);

  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_ILL = 2'b01;
  localparam logic [1:0] ERR_BUS = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, RSP, ERR} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
  } bus_cmd_t;

  state_t           state_q, state_d;
  bus_cmd_t         cmd_q, cmd_d, cmd_new;
  logic             bus_req_q, bus_req_d;
  logic             we_q, we_d;
  logic [2:0]       size_q, size_d;
  logic [1:0]       off_q, off_d;
  logic [4:0]       rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, stall_q;
  logic             rsp_valid_q, rsp_valid_d;
  logic [4:0]       rsp_rd_q, rsp_rd_d;
  logic [1:0]       rsp_err_q, rsp_err_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;

  logic             illegal;
  logic             to_hit;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic             sext;
  logic [31:0]      load_data;

  // Request legality: unsupported sizes, unsigned stores and misaligned halves/words
  always_comb begin
    illegal = 1'b0;
    case (req_size_i)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = req_addr_i[0];
      3'b010:  illegal = |req_addr_i[1:0];
      3'b100:  illegal = req_we_i;
      3'b101:  illegal = req_we_i | req_addr_i[0];
      default: illegal = 1'b1;
    endcase
  end

  // Bus command for a newly accepted request
  always_comb begin
    cmd_new.we   = req_we_i;
    cmd_new.addr = {req_addr_i[ADDR_W-1:2], 2'b00};
    case (req_size_i[1:0])
      2'b00: begin
        cmd_new.be    = 4'b0001 << req_addr_i[1:0];
        cmd_new.wdata = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        cmd_new.be    = 4'b0011 << req_addr_i[1:0];
        cmd_new.wdata = {2{req_wdata_i[15:0]}};
      end
      default: begin
        cmd_new.be    = 4'b1111;
        cmd_new.wdata = req_wdata_i;
      end
    endcase
    if (!req_we_i) cmd_new.wdata = '0;
  end

  // Lane selection and sign/zero extension of the returned word
  always_comb begin
    case (off_q)
      2'd0:    lane_b = bus_rdata_i[7:0];
      2'd1:    lane_b = bus_rdata_i[15:8];
      2'd2:    lane_b = bus_rdata_i[23:16];
      default: lane_b = bus_rdata_i[31:24];
    endcase
    lane_h = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    sext   = !size_q[2];
    case (size_q[1:0])
      2'b00:   load_data = {{24{sext & lane_b[7]}}, lane_b};
      2'b01:   load_data = {{16{sext & lane_h[15]}}, lane_h};
      default: load_data = bus_rdata_i;
    endcase
  end

  // Counter at or past the last allowed cycle; a completion event in that cycle still wins
  assign to_hit = (TIMEOUT != 0) && (cnt_q >= CNT_W'(TO_LAST));

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    bus_req_d   = 1'b0;
    we_d        = we_q;
    size_d      = size_q;
    off_d       = off_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rd_d    = rsp_rd_q;
    rsp_err_d   = ERR_OK;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d   = req_we_i;
          size_d = req_size_i;
          off_d  = req_addr_i[1:0];
          rd_d   = req_rd_addr_i;
          if (illegal) begin
            state_d = ERR;
          end else begin
            state_d   = REQ;
            cmd_d     = cmd_new;
            bus_req_d = 1'b1;
            cnt_d     = '0;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_gnt_i) begin
          state_d = RSP;
        end else if (to_hit) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rd_d    = rd_q;
          rsp_err_d   = ERR_TMO;
        end else begin
          bus_req_d = 1'b1;
        end
      end
      RSP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_rvalid_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rd_d    = rd_q;
          rsp_err_d   = bus_err_i ? ERR_BUS : ERR_OK;
          rsp_rdata_d = (!we_q && !bus_err_i) ? load_data : 32'd0;
        end else if (to_hit) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rd_d    = rd_q;
          rsp_err_d   = ERR_TMO;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_rd_d    = rd_q;
        rsp_err_d   = ERR_ILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      bus_req_q   <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      stall_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= '0;
      rsp_err_q   <= ERR_OK;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      bus_req_q   <= bus_req_d;
      we_q        <= we_d;
      size_q      <= size_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      ready_q     <= (state_d == IDLE);
      stall_q     <= (state_d != IDLE);
      rsp_valid_q <= rsp_valid_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready_o   = ready_q;
  assign stall_o       = stall_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rd_addr_o = rsp_rd_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign bus_req_o     = bus_req_q;
  assign bus_we_o      = cmd_q.we;
  assign bus_addr_o    = cmd_q.addr;
  assign bus_be_o      = cmd_q.be;
  assign bus_wdata_o   = cmd_q.wdata;

endmodule

// File: tb/tb_lsu_bus.sv
// Scoreboard bench for lsu_bus: directed cases then random accesses against a transaction-level model.
module tb_lsu_bus;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_we_i;
  logic [2:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [4:0]  req_rd_addr_i;
  logic        req_ready_o, stall_o, rsp_valid_o;
  logic [4:0]  rsp_rd_addr_o;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_err_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i, bus_rvalid_i, bus_err_i;
  logic [31:0] bus_rdata_i;

  lsu_bus #(.ADDR_W(32), .TIMEOUT(T), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_addr_i(req_rd_addr_i),
    .req_ready_o(req_ready_o), .stall_o(stall_o),
    .rsp_valid_o(rsp_valid_o), .rsp_rd_addr_o(rsp_rd_addr_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [1:0]  err;
    logic [31:0] data;
  } rsp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } cmd_t;

  rsp_t rsp_q[$];
  cmd_t cmd_q[$];
  rsp_t rsp_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   bus_seen = 0;
  int   bus_exp = 0;
  logic busy = 1'b0;
  logic prev_req = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: handshake flags, response scoreboard and bus command scoreboard
  always @(negedge clk) begin
    if (rst) begin
      check("stall", 128'(stall_o), 128'(busy));
      check("ready", 128'(req_ready_o), 128'(!busy));
      if (rsp_valid_o) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", 128'(rsp_valid_o), 128'(0));
        else begin
          rsp_e = rsp_q.pop_front();
          check("rsp", 128'({rsp_rd_addr_o, rsp_err_o, rsp_rdata_o}), 128'(rsp_e));
        end
      end
      if (bus_req_o) begin
        if (!prev_req) bus_seen++;
        if (cmd_q.size() == 0) check("bus_unexpected", 128'(bus_req_o), 128'(0));
        else check("bus_cmd", 128'({bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o}), 128'(cmd_q[0]));
      end else if (prev_req && cmd_q.size() != 0) begin
        void'(cmd_q.pop_front());
      end
      prev_req = bus_req_o;
    end
  end

  // One access: g = REQ cycles before gnt, r = RSP cycles before rvalid
  task automatic run_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input int unsigned g, input int unsigned r,
                         input logic [31:0] rdata, input logic berr, input logic stray);
    int unsigned nb, lat, cyc;
    logic        legal, tmo;
    logic [31:0] lane, val;
    rsp_t        e;
    cmd_t        c;
    case (size)
      3'b000:  nb = 1;
      3'b001:  nb = 2;
      3'b010:  nb = 4;
      3'b100:  nb = we ? 0 : 1;
      3'b101:  nb = we ? 0 : 2;
      default: nb = 0;
    endcase
    legal = (nb != 0) && ((addr % nb) == 0);
    tmo   = legal && ((g >= T) || (r > 0 && g + r >= T - 1));
    e.rd  = rd;
    if (!legal) begin
      e.err = 2'b01; e.data = 32'd0; lat = 1;
    end else if (tmo) begin
      e.err = 2'b11; e.data = 32'd0;
      lat = (g >= T) ? T : (((g + 1 > T - 1) ? g + 1 : T - 1) + 1);
    end else begin
      lat   = g + r + 2;
      e.err = berr ? 2'b10 : 2'b00;
      lane  = rdata >> (8 * addr[1:0]);
      if (nb == 1)      val = size[2] ? (lane & 32'hFF)   : 32'($signed(lane[7:0]));
      else if (nb == 2) val = size[2] ? (lane & 32'hFFFF) : 32'($signed(lane[15:0]));
      else              val = rdata;
      e.data = (berr || we) ? 32'd0 : val;
    end
    rsp_q.push_back(e);
    if (legal) begin
      c.we    = we;
      c.addr  = addr & 32'hFFFF_FFFC;
      c.be    = 4'(((1 << nb) - 1) << addr[1:0]);
      if (!we)          c.wdata = 32'd0;
      else if (nb == 1) c.wdata = (wdata & 32'hFF) * 32'h0101_0101;
      else if (nb == 2) c.wdata = (wdata & 32'hFFFF) * 32'h0001_0001;
      else              c.wdata = wdata;
      cmd_q.push_back(c);
      bus_exp++;
    end
    req_we_i = we; req_size_i = size; req_addr_i = addr;
    req_wdata_i = wdata; req_rd_addr_i = rd; req_valid_i = 1'b1;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    req_wdata_i = $urandom;
    busy = 1'b1;
    cyc = 0;
    while (!rsp_valid_o && cyc < 40) begin
      bus_gnt_i    = (cyc == g);
      bus_rvalid_i = (cyc == g + 1 + r) || (stray && cyc == g);
      if (cyc == g + 1 + r) begin
        bus_rdata_i = rdata; bus_err_i = berr;
      end else begin
        bus_rdata_i = $urandom; bus_err_i = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 128'(cyc), 128'(lat));
    busy = 1'b0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
  endtask

  logic [2:0] size_tab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3, 3'd6, 3'd7};

  initial begin
    logic [31:0] a;
    rst = 1'b0;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = '0; req_addr_i = '0;
    req_wdata_i = '0; req_rd_addr_i = '0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0; bus_err_i = 1'b0;
    #12;
    check("reset_outputs", 128'({stall_o, rsp_valid_o, rsp_rd_addr_o, rsp_err_o, rsp_rdata_o,
          bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o}), 128'(0));
    check("reset_ready", 128'(req_ready_o), 128'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    run_txn(1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 0, 0, 32'h80FF_1234, 1'b0, 1'b0);
    run_txn(1'b0, 3'b100, 32'h103, 32'h0, 5'd8, 0, 0, 32'h80FF_1234, 1'b0, 1'b0);
    run_txn(1'b1, 3'b001, 32'h202, 32'hDEAD_BEEF, 5'd9, 3, 0, 32'h1111_2222, 1'b0, 1'b0);
    run_txn(1'b0, 3'b010, 32'h001, 32'h0, 5'd10, 0, 0, 32'h0, 1'b0, 1'b0);
    run_txn(1'b1, 3'b100, 32'h010, 32'hA5, 5'd11, 0, 0, 32'h0, 1'b0, 1'b0);
    run_txn(1'b0, 3'b010, 32'h300, 32'h0, 5'd12, 0, 9, 32'h0, 1'b0, 1'b0);
    run_txn(1'b0, 3'b010, 32'h304, 32'h0, 5'd13, 0, 2, 32'hCAFE_F00D, 1'b0, 1'b0);
    run_txn(1'b0, 3'b001, 32'h002, 32'h0, 5'd14, 1, 0, 32'h1234_ABCD, 1'b1, 1'b1);

    // Reset while waiting for the response, then a stray rvalid
    cmd_q.push_back('{we: 1'b0, addr: 32'h40, be: 4'hF, wdata: 32'h0});
    bus_exp++;
    req_we_i = 1'b0; req_size_i = 3'b010; req_addr_i = 32'h40; req_rd_addr_i = 5'd3;
    req_valid_i = 1'b1;
    @(posedge clk); #1 req_valid_i = 1'b0; busy = 1'b1; bus_gnt_i = 1'b1;
    @(posedge clk); #1 bus_gnt_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0; busy = 1'b0;
    #1;
    check("rst_outputs", 128'({stall_o, rsp_valid_o, rsp_rd_addr_o, rsp_err_o, rsp_rdata_o,
          bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o}), 128'(0));
    check("rst_ready", 128'(req_ready_o), 128'(1));
    @(posedge clk); #1 rst = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
    @(posedge clk); #1 bus_rvalid_i = 1'b0;
    check("rst_no_rsp", 128'(rsp_valid_o), 128'(0));
    check("rst_idle_ready", 128'(req_ready_o), 128'(1));

    for (int i = 0; i < 300; i++) begin
      int unsigned gap;
      gap = $urandom_range(0, 2);
      for (int k = 0; k < int'(gap); k++) begin
        bus_gnt_i = 1'($urandom_range(0, 1));
        bus_rvalid_i = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_txn(1'($urandom_range(0, 1)), size_tab[$urandom_range(0, 9)], a, $urandom,
              5'($urandom_range(0, 31)), $urandom_range(0, 5), $urandom_range(0, 5),
              $urandom, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bus_count", 128'(bus_seen), 128'(bus_exp));
    check("rsp_drain", 128'(rsp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
